// File: rtl/rx_memory_control.sv
// -----------------------------------------------------------------------------
// rx_memory_control
//
// Receive-side VRAM writer. De-framed Ethernet payload segments are staged
// byte by byte in a local RAM. The segment is checked at end of frame: CRC
// verdict, exact length, segment range, and whether it was already committed
// for the current video frame. A good segment is replayed from staging as
// {R,G,B} pixels into the display VRAM write port. Anything else is dropped.
// A segment number lower than the last committed one marks the start of a new
// video frame and clears the committed bitmap.
//
// Ports
//   clk125MHz, rst            : RX clock, asynchronous active-high reset
//   rx_sof/valid/data/eof     : payload byte stream from the RX parser
//   rx_txid, rx_segment_num   : segment header fields, valid with rx_sof
//   rx_frame_ok               : CRC/length verdict, valid with rx_eof
//   rx_ready                  : high while a new segment may start
//   vram_we/addr/din          : VRAM pixel write port
//   seg_committed/seg_dropped : one-cycle status pulses
//   last_txid, commit_count, drop_count : status registers
// -----------------------------------------------------------------------------
module rx_memory_control #(
  parameter int SEGMENT_NUMBER_MAX = 500,
  parameter int SEGMENT_BYTES      = 1080
) (
  input  logic        clk125MHz,
  input  logic        rst,
  input  logic        rx_sof,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic [7:0]  rx_txid,
  input  logic [15:0] rx_segment_num,
  input  logic        rx_eof,
  input  logic        rx_frame_ok,
  output logic        rx_ready,
  output logic        vram_we,
  output logic [23:0] vram_addr,
  output logic [23:0] vram_din,
  output logic        seg_committed,
  output logic        seg_dropped,
  output logic [7:0]  last_txid,
  output logic [15:0] commit_count,
  output logic [15:0] drop_count
);

  localparam int PIX_PER_SEG = SEGMENT_BYTES / 3;
  // Byte counter must reach SEGMENT_BYTES+1 (the oversize saturation value).
  localparam int CW = $clog2(SEGMENT_BYTES + 2);
  localparam int SW = $clog2(SEGMENT_NUMBER_MAX);

  localparam logic [CW-1:0] BYTES_C   = CW'(SEGMENT_BYTES);
  localparam logic [CW-1:0] BYTES_SAT = CW'(SEGMENT_BYTES + 1);
  localparam logic [15:0]   PIX_LAST  = 16'(PIX_PER_SEG - 1);
  localparam logic [23:0]   PIX_24    = 24'(PIX_PER_SEG);
  localparam logic [15:0]   SEG_MAX   = 16'(SEGMENT_NUMBER_MAX);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RECV   = 2'd1;
  localparam logic [1:0] S_CHECK  = 2'd2;
  localparam logic [1:0] S_COMMIT = 2'd3;

  logic [1:0]                    state_q, state_d;
  logic [15:0]                   seg_num_q, seg_num_d;
  logic [7:0]                    txid_q, txid_d;
  logic [CW-1:0]                 byte_cnt_q, byte_cnt_d;
  logic                          frame_ok_q, frame_ok_d;
  logic [SEGMENT_NUMBER_MAX-1:0] bitmap_q, bitmap_d;
  logic [15:0]                   last_seg_q, last_seg_d;
  logic [7:0]                    last_txid_q, last_txid_d;
  logic [23:0]                   base_q, base_d;
  logic [CW-1:0]                 rd_addr_q, rd_addr_d;
  logic                          rd_vld_q, rd_vld_d;
  logic [1:0]                    phase_q, phase_d;
  logic [15:0]                   pix_q, pix_d;
  logic [15:0]                   pix_idx_q, pix_idx_d;
  logic                          vram_we_q, vram_we_d;
  logic [23:0]                   vram_addr_q, vram_addr_d;
  logic [23:0]                   vram_din_q, vram_din_d;
  logic                          seg_committed_q, seg_committed_d;
  logic                          seg_dropped_q, seg_dropped_d;
  logic [15:0]                   commit_count_q, commit_count_d;
  logic [15:0]                   drop_count_q, drop_count_d;

  // Staging RAM ports
  logic [7:0]    stage_mem [SEGMENT_BYTES];
  logic          ram_we, ram_re;
  logic [CW-1:0] ram_waddr;
  logic [7:0]    ram_rdata_q;

  logic       start_seg, seg_in_range, bit_set, new_frame, accept;
  logic [1:0] drop_inc;

  assign rx_ready = (state_q == S_IDLE) || (state_q == S_RECV);

  // Acceptance is decided in CHECK from values registered during RECV.
  assign seg_in_range = seg_num_q < SEG_MAX;
  assign bit_set      = seg_in_range ? bitmap_q[seg_num_q[SW-1:0]] : 1'b0;
  assign new_frame    = seg_num_q < last_seg_q;
  assign accept       = frame_ok_q && (byte_cnt_q == BYTES_C) && seg_in_range &&
                        !(bit_set && !new_frame);

  assign start_seg = rx_sof && rx_ready;

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d         = state_q;
    seg_num_d       = seg_num_q;
    txid_d          = txid_q;
    byte_cnt_d      = byte_cnt_q;
    frame_ok_d      = frame_ok_q;
    bitmap_d        = bitmap_q;
    last_seg_d      = last_seg_q;
    last_txid_d     = last_txid_q;
    base_d          = base_q;
    rd_addr_d       = rd_addr_q;
    rd_vld_d        = 1'b0;
    phase_d         = phase_q;
    pix_d           = pix_q;
    pix_idx_d       = pix_idx_q;
    vram_we_d       = 1'b0;
    vram_addr_d     = vram_addr_q;
    vram_din_d      = vram_din_q;
    seg_committed_d = 1'b0;
    seg_dropped_d   = 1'b0;
    commit_count_d  = commit_count_q;
    drop_inc        = 2'd0;
    ram_we          = 1'b0;
    ram_re          = 1'b0;
    ram_waddr       = byte_cnt_q;

    case (state_q)
      S_RECV: begin
        if (rx_sof) begin
          // Restart before eof: abandon the segment in flight.
          drop_inc      = drop_inc + 2'd1;
          seg_dropped_d = 1'b1;
        end else begin
          if (rx_valid) begin
            ram_we = byte_cnt_q < BYTES_C;
            if (byte_cnt_q != BYTES_SAT) byte_cnt_d = byte_cnt_q + 1'b1;
          end
          if (rx_eof) begin
            frame_ok_d = rx_frame_ok;
            state_d    = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        if (accept) begin
          bitmap_d = new_frame ? '0 : bitmap_q;
          bitmap_d[seg_num_q[SW-1:0]] = 1'b1;
          last_seg_d  = seg_num_q;
          last_txid_d = txid_q;
          base_d      = 24'(seg_num_q) * PIX_24;
          rd_addr_d   = '0;
          phase_d     = 2'd0;
          pix_idx_d   = '0;
          state_d     = S_COMMIT;
        end else begin
          drop_inc      = drop_inc + 2'd1;
          seg_dropped_d = 1'b1;
          state_d       = S_IDLE;
        end
      end
      S_COMMIT: begin
        // Read issue side: one staging byte per cycle.
        if (rd_addr_q < BYTES_C) begin
          ram_re    = 1'b1;
          rd_vld_d  = 1'b1;
          rd_addr_d = rd_addr_q + 1'b1;
        end
        // Data side: assemble R,G,B, write on the blue byte.
        if (rd_vld_q) begin
          case (phase_q)
            2'd0:    begin pix_d[15:8] = ram_rdata_q; phase_d = 2'd1; end
            2'd1:    begin pix_d[7:0]  = ram_rdata_q; phase_d = 2'd2; end
            default: begin
              vram_we_d   = 1'b1;
              vram_din_d  = {pix_q, ram_rdata_q};
              vram_addr_d = base_q + 24'(pix_idx_q);
              pix_idx_d   = pix_idx_q + 16'd1;
              phase_d     = 2'd0;
              if (pix_idx_q == PIX_LAST) begin
                seg_committed_d = 1'b1;
                commit_count_d  = commit_count_q + 16'd1;
              end
            end
          endcase
        end
        // Leave only after the last write has been presented.
        if (seg_committed_q) state_d = S_IDLE;
      end
      default: ;
    endcase

    if (start_seg) begin
      seg_num_d  = rx_segment_num;
      txid_d     = rx_txid;
      ram_we     = 1'b1;
      ram_waddr  = '0;
      byte_cnt_d = CW'(1);
      state_d    = S_RECV;
    end

    // A segment offered while busy is discarded whole.
    if (rx_sof && !rx_ready) begin
      drop_inc      = drop_inc + 2'd1;
      seg_dropped_d = 1'b1;
    end

    drop_count_d = drop_count_q + 16'(drop_inc);
  end

  // NOTE: the staging RAM has no reset; its contents are only read after a
  // complete, length-checked segment has overwritten every location.
  always_ff @(posedge clk125MHz) begin
    if (ram_we) stage_mem[ram_waddr] <= rx_data;
    if (ram_re) ram_rdata_q <= stage_mem[rd_addr_q];
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk125MHz or posedge rst) begin
    if (rst) begin
      state_q         <= S_IDLE;
      seg_num_q       <= '0;
      txid_q          <= '0;
      byte_cnt_q      <= '0;
      frame_ok_q      <= 1'b0;
      bitmap_q        <= '0;
      last_seg_q      <= '0;
      last_txid_q     <= '0;
      base_q          <= '0;
      rd_addr_q       <= '0;
      rd_vld_q        <= 1'b0;
      phase_q         <= '0;
      pix_q           <= '0;
      pix_idx_q       <= '0;
      vram_we_q       <= 1'b0;
      vram_addr_q     <= '0;
      vram_din_q      <= '0;
      seg_committed_q <= 1'b0;
      seg_dropped_q   <= 1'b0;
      commit_count_q  <= '0;
      drop_count_q    <= '0;
    end else begin
      state_q         <= state_d;
      seg_num_q       <= seg_num_d;
      txid_q          <= txid_d;
      byte_cnt_q      <= byte_cnt_d;
      frame_ok_q      <= frame_ok_d;
      bitmap_q        <= bitmap_d;
      last_seg_q      <= last_seg_d;
      last_txid_q     <= last_txid_d;
      base_q          <= base_d;
      rd_addr_q       <= rd_addr_d;
      rd_vld_q        <= rd_vld_d;
      phase_q         <= phase_d;
      pix_q           <= pix_d;
      pix_idx_q       <= pix_idx_d;
      vram_we_q       <= vram_we_d;
      vram_addr_q     <= vram_addr_d;
      vram_din_q      <= vram_din_d;
      seg_committed_q <= seg_committed_d;
      seg_dropped_q   <= seg_dropped_d;
      commit_count_q  <= commit_count_d;
      drop_count_q    <= drop_count_d;
    end
  end

  assign vram_we       = vram_we_q;
  assign vram_addr     = vram_addr_q;
  assign vram_din      = vram_din_q;
  assign seg_committed = seg_committed_q;
  assign seg_dropped   = seg_dropped_q;
  assign last_txid     = last_txid_q;
  assign commit_count  = commit_count_q;
  assign drop_count    = drop_count_q;

endmodule
